// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit driving a word-aligned request/ack data bus.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic        op_read,
  input  logic        op_write,
  input  logic [2:0]  op_size,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        lsu_stall,
  output logic [31:0] lsu_rdata,
  output logic        lsu_done,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, cnt_q, cnt_d;
  logic [3:0] be_q, be_d;
  logic [2:0] size_q, size_d;
  logic [1:0] off_q, off_d;
  logic we_q, we_d, err_q, err_d;
  logic access, mis, op_b, op_h, ld_b, ld_h, timeout, idle_mis;
  logic [31:0] shifted, ext;
  // Size codes outside b/h/bu/hu fall through to word handling.
  assign op_b = op_size[1:0] == 2'b00;
  assign op_h = op_size[1:0] == 2'b01;
  assign ld_b = size_q[1:0] == 2'b00;
  assign ld_h = size_q[1:0] == 2'b01;
  assign access = op_valid & (op_read | op_write);
  assign mis = access & (op_h ? op_addr[0] : (!op_b & (op_addr[1:0] != 2'b00)));
  assign shifted = bus_rdata >> {off_q, 3'b000};
  assign ext = ld_b ? {{24{~size_q[2] & shifted[7]}}, shifted[7:0]}
             : ld_h ? {{16{~size_q[2] & shifted[15]}}, shifted[15:0]} : shifted;
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    be_d    = be_q;
    size_d  = size_q;
    off_d   = off_q;
    we_d    = we_q;
    err_d   = err_q;
    if (state_q == IDLE) begin
      if (mis) rdata_d = '0;
      else if (access) begin
        state_d = WAIT;
        addr_d  = {op_addr[31:2], 2'b00};
        we_d    = op_write;
        be_d    = op_b ? 4'b0001 << op_addr[1:0] : op_h ? 4'b0011 << {op_addr[1], 1'b0} : 4'b1111;
        wdata_d = op_b ? {4{op_wdata[7:0]}} : op_h ? {2{op_wdata[15:0]}} : op_wdata;
        off_d   = op_addr[1:0];
        size_d  = op_size;
        err_d   = 1'b0;
        cnt_d   = '0;
      end
    end else if (state_q == WAIT) begin
      if (bus_ack) begin
        state_d = DONE;
        rdata_d = we_q ? '0 : ext;
      end else if (timeout) begin
        state_d = DONE;
        rdata_d = '0;
        err_d   = 1'b1;
      end else cnt_d = cnt_q + 32'd1;
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      be_q    <= '0;
      size_q  <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      be_q    <= be_d;
      size_q  <= size_d;
      off_q   <= off_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end
  // Combinational terms are gated by rst so outputs drop immediately on reset.
  assign idle_mis     = !rst & (state_q == IDLE) & mis;
  assign lsu_stall    = !rst & ((state_q == WAIT) | ((state_q == IDLE) & access & !mis));
  assign lsu_done     = (state_q == DONE) | idle_mis;
  assign misalign_err = idle_mis;
  assign bus_err      = (state_q == DONE) & err_q;
  assign lsu_rdata    = idle_mis ? '0 : rdata_q;
  assign bus_req      = state_q == WAIT;
  assign bus_we       = we_q;
  assign bus_addr     = addr_q;
  assign bus_be       = be_q;
  assign bus_wdata    = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store, misalign, timeout and reset checks.
module tb_mem_access_unit;
  logic clk = 0, rst = 1;
  logic op_valid = 0, op_read = 0, op_write = 0;
  logic [2:0] op_size = 0;
  logic [31:0] op_addr = 0, op_wdata = 0;
  logic lsu_stall, lsu_done, misalign_err, bus_err, bus_req, bus_we;
  logic [31:0] lsu_rdata, bus_addr, bus_wdata;
  logic [3:0] bus_be;
  logic bus_ack = 0;
  logic [31:0] bus_rdata = 0;
  int checks = 0, errors = 0;
  int req_n, lat;
  logic [31:0] c_addr, c_wdata, r_data;
  logic [3:0] c_be;
  logic c_we, r_done, r_err, r_stall, s_stall, stall_drop;

  mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_read(op_read), .op_write(op_write),
    .op_size(op_size), .op_addr(op_addr), .op_wdata(op_wdata), .lsu_stall(lsu_stall),
    .lsu_rdata(lsu_rdata), .lsu_done(lsu_done), .misalign_err(misalign_err), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Issue one access at #1 after an edge; nwait<0 never acks. Returns one cycle after DONE.
  task automatic run(input logic wr, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                     input int nwait, input logic [31:0] rd);
    op_valid = 1; op_read = !wr; op_write = wr; op_size = sz; op_addr = a; op_wdata = wd;
    #1;
    s_stall = lsu_stall; req_n = 0; lat = 0; r_done = 0; stall_drop = 0;
    for (int i = 1; i <= 40 && !r_done; i++) begin
      @(posedge clk); #1;
      if (bus_req) begin
        req_n++;
        if (req_n == 1) begin
          c_addr = bus_addr; c_be = bus_be; c_wdata = bus_wdata; c_we = bus_we;
        end
        if (!lsu_stall) stall_drop = 1;
        bus_ack = (nwait >= 0) && (req_n == nwait + 1);
        bus_rdata = rd;
      end else begin
        bus_ack = 0;
        r_done = lsu_done; r_err = bus_err; r_data = lsu_rdata; r_stall = lsu_stall; lat = i;
      end
    end
    op_valid = 0; bus_ack = 0;
    check("done_seen", r_done, 1);
    check("stall_accept", s_stall, 1);
    check("stall_wait", stall_drop, 0);
    check("stall_done", r_stall, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    op_valid = 1; op_read = 1; op_size = 3'b010; op_addr = 32'h1000;
    #2;
    check("rst_stall", lsu_stall, 0);
    check("rst_req", bus_req, 0);
    check("rst_done", lsu_done, 0);
    check("rst_rdata", lsu_rdata, 0);
    check("rst_be", bus_be, 0);
    @(posedge clk); #1 rst = 0; op_valid = 0;
    @(posedge clk); #1;

    run(0, 3'b010, 32'h0000_1004, 0, 0, 32'hDEAD_BEEF);
    check("lw_addr", c_addr, 32'h0000_1004);
    check("lw_be", c_be, 4'b1111);
    check("lw_we", c_we, 0);
    check("lw_req", req_n, 1);
    check("lw_lat", lat, 2);
    check("lw_data", r_data, 32'hDEAD_BEEF);
    check("lw_err", r_err, 0);

    run(0, 3'b000, 32'h0000_2003, 0, 0, 32'h80FF_1234);
    check("lb_addr", c_addr, 32'h0000_2000);
    check("lb_be", c_be, 4'b1000);
    check("lb_data", r_data, 32'hFFFF_FF80);

    run(1, 3'b001, 32'h0000_3002, 32'h0000_ABCD, 3, 32'h5555_5555);
    check("sh_we", c_we, 1);
    check("sh_be", c_be, 4'b1100);
    check("sh_wdata", c_wdata, 32'hABCD_ABCD);
    check("sh_req", req_n, 4);
    check("sh_lat", lat, 5);
    check("sh_data", r_data, 0);

    run(0, 3'b100, 32'h0000_2003, 0, 0, 32'h80FF_1234);
    check("lbu_data", r_data, 32'h0000_0080);

    op_valid = 1; op_read = 1; op_write = 0; op_size = 3'b010; op_addr = 32'h0000_4001;
    #1;
    check("mis_err", misalign_err, 1);
    check("mis_done", lsu_done, 1);
    check("mis_stall", lsu_stall, 0);
    check("mis_rdata", lsu_rdata, 0);
    check("mis_req", bus_req, 0);
    @(posedge clk); #1;
    check("mis_req_next", bus_req, 0);
    op_valid = 0; #1;
    check("mis_err_clear", misalign_err, 0);
    check("mis_rdata_hold", lsu_rdata, 0);
    @(posedge clk); #1;

    run(0, 3'b001, 32'h0000_5002, 0, 1, 32'h8765_4321);
    check("lh_be", c_be, 4'b1100);
    check("lh_data", r_data, 32'hFFFF_8765);

    run(0, 3'b010, 32'h0000_6000, 0, -1, 32'h1111_1111);
    check("to_req", req_n, 16);
    check("to_err", r_err, 1);
    check("to_data", r_data, 0);
    check("to_idle_req", bus_req, 0);
    check("to_err_clear", bus_err, 0);

    op_valid = 1; op_read = 1; op_write = 0; op_size = 3'b010; op_addr = 32'h0000_7000;
    @(posedge clk); #1;
    check("rw_req", bus_req, 1);
    #2 rst = 1;
    #1;
    check("rw_req_drop", bus_req, 0);
    check("rw_stall_drop", lsu_stall, 0);
    check("rw_done", lsu_done, 0);
    @(posedge clk); #1 rst = 0; op_valid = 0; bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1 bus_ack = 0;
    check("ack_idle_req", bus_req, 0);
    check("ack_idle_done", lsu_done, 0);
    check("ack_idle_rdata", lsu_rdata, 0);

    run(0, 3'b010, 32'h0000_6000, 0, 0, 32'h1234_5678);
    check("post_rst_addr", c_addr, 32'h0000_6000);
    check("post_rst_data", r_data, 32'h1234_5678);
    check("post_rst_lat", lat, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
